// File: rtl/plot_pkg.sv
// Shared constants, FSM encoding and pixel address mapping for the plot receiver.
package plot_pkg;

  localparam int H_RES     = 160;
  localparam int V_RES     = 120;
  localparam int PIX_COUNT = H_RES * V_RES;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_CLEAR_WAIT = 2'd1,
    ST_CLEAR_FILL = 2'd2
  } state_e;

  // y*H_RES + x; 160 = 128 + 32, so the default resolution needs only shifts and adds.
  function automatic logic [31:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [31:0] yy;
    logic [31:0] xx;
    yy = {25'd0, y};
    xx = {24'd0, x};
    if (H_RES == 160) return (yy << 7) + (yy << 5) + xx;
    else              return (yy * 32'(H_RES)) + xx;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding queued {addr, colour} plot entries.
// Push is ignored when full and pop when empty; push+pop together keeps the count.
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_dat_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == FULL_CNT);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/plot_receiver.sv
// Queues plot requests, maps (x,y) to framebuffer addresses and drains them under mem_ready;
// also sweeps the whole screen with a fill colour on clear_req once queued pixels are written.
module plot_receiver
  import plot_pkg::*;
#(
  parameter int COLOUR_W = 3,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 15
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [7:0]                 in_x,
  input  logic [6:0]                 in_y,
  input  logic [COLOUR_W-1:0]        in_colour,
  input  logic                       clear_req,
  input  logic [COLOUR_W-1:0]        clear_colour,
  output logic                       clear_done,
  output logic                       drop,
  output logic                       busy,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [COLOUR_W-1:0]        mem_data,
  input  logic                       mem_ready,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int ENT_W = ADDR_W + COLOUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIX_COUNT - 1);
  localparam logic [7:0] X_LIM = 8'(H_RES);
  localparam logic [6:0] Y_LIM = 7'(V_RES);

  state_e               state_q, state_d;
  logic                 fifo_full, fifo_empty;
  logic [ENT_W-1:0]     fifo_head, push_dat;
  logic [31:0]          lin_addr;
  logic                 accept, in_range, push, pop, out_load, last_fill;
  logic                 out_vld_q;
  logic [ADDR_W-1:0]    out_addr_q, clr_cnt_q;
  logic [COLOUR_W-1:0]  out_data_q, clr_colour_q;
  logic                 clear_done_q, drop_q;

  assign lin_addr  = pix_addr(in_x, in_y);
  assign push_dat  = {lin_addr[ADDR_W-1:0], in_colour};
  assign accept    = in_valid & in_ready;
  assign in_range  = (in_x < X_LIM) & (in_y < Y_LIM);
  assign push      = accept & in_range;
  // The output register reloads whenever it is empty or its current write is being taken.
  assign out_load  = ~out_vld_q | mem_ready;
  assign pop       = out_load & ~fifo_empty;
  assign last_fill = (state_q == ST_CLEAR_FILL) & mem_ready & (clr_cnt_q == LAST_ADDR);

  pixel_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_dat_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:        if (clear_req) state_d = ST_CLEAR_WAIT;
      ST_CLEAR_WAIT: if (fifo_empty && (!out_vld_q || mem_ready)) state_d = ST_CLEAR_FILL;
      ST_CLEAR_FILL: if (last_fill) state_d = ST_RUN;
      default:       state_d = ST_RUN;
    endcase
  end

  always_comb begin
    in_ready = (state_q == ST_RUN) & ~fifo_full;
    mem_we   = out_vld_q;
    mem_addr = out_addr_q;
    mem_data = out_data_q;
    if (state_q == ST_CLEAR_FILL) begin
      mem_we   = 1'b1;
      mem_addr = clr_cnt_q;
      mem_data = clr_colour_q;
    end
    busy       = (state_q != ST_RUN) | (fifo_count != '0) | mem_we;
    clear_done = clear_done_q;
    drop       = drop_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else if (out_load) begin
      out_vld_q <= ~fifo_empty;
      if (!fifo_empty) {out_addr_q, out_data_q} <= fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt_q    <= '0;
      clr_colour_q <= '0;
      clear_done_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      clear_done_q <= last_fill;
      drop_q       <= (in_valid & ~in_ready) | (accept & ~in_range);
      if (state_q == ST_RUN && clear_req) clr_colour_q <= clear_colour;
      if (state_q == ST_CLEAR_FILL && mem_ready)
        clr_cnt_q <= last_fill ? '0 : clr_cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/plot_receiver.md
Name: plot_receiver

Overview:
- Receiving end of the pixel-plot interface that drawing units drive: x, y, colour and a plot strobe.
- Buffers incoming plot requests in a small FIFO, converts (x,y) to a linear framebuffer address, and drains them to the framebuffer memory write port under mem_ready backpressure.
- Also performs a full-screen clear sweep on request, so drawing units do not have to erase themselves.
- Sits between the UI drawing controllers and the framebuffer RAM, in place of direct x/y/plot wiring.

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in pixels.
- COLOUR_W, 3, colour bits per pixel.
- DEPTH, 8, FIFO entries (power of two).
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk, in, 1, single system clock; all logic on posedge.
- reset, in, 1, synchronous, active-high reset.
- in_valid, in, 1, plot request strobe.
- in_ready, out, 1, receiver can accept this cycle.
- in_x, in, 8, pixel column.
- in_y, in, 7, pixel row.
- in_colour, in, COLOUR_W, pixel colour.
- clear_req, in, 1, start full-screen clear.
- clear_colour, in, COLOUR_W, fill colour; sampled when the clear is accepted.
- clear_done, out, 1, one-cycle pulse when the last clear write completes.
- drop, out, 1, one-cycle pulse when a request is refused or discarded.
- busy, out, 1, work pending.
- mem_we, out, 1, write request to the framebuffer.
- mem_addr, out, ADDR_W, write address = y*H_RES + x.
- mem_data, out, COLOUR_W, write data.
- mem_ready, in, 1, memory accepts the write this cycle.
- fifo_count, out, $clog2(DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (clk edge with reset=1): state RUN, FIFO emptied, output register invalid, clear counter 0.
  - Outputs after reset: mem_we=0, mem_addr=0, mem_data=0, clear_done=0, drop=0, busy=0, fifo_count=0, in_ready=1.
  - Reset mid-operation discards all pending pixels and any clear sweep in progress; clear_done does not pulse.
- Handshake:
  - A request is accepted when in_valid & in_ready at a clock edge.
  - in_ready = (state==RUN) & !fifo_full. A push into a full FIFO is never allowed, even when a pop occurs in the same cycle.
  - in_valid & !in_ready → request is lost and drop pulses the next cycle.
- Range check: an accepted request with in_x>=H_RES or in_y>=V_RES is consumed, not stored, and drop pulses the next cycle.
- Address: mem_addr = in_y*H_RES + in_x, computed at FIFO input as (y<<7)+(y<<5)+x for the default resolution. The FIFO stores {addr, colour}.
- Output stage: one register holding mem_we/mem_addr/mem_data.
  - Loads from the FIFO head when it is invalid, or when it is valid and mem_ready=1 (pop and reload in the same cycle, giving one write per cycle sustained).
  - While mem_we=1 and mem_ready=0, addr and data are held stable.
- Latency: a pixel accepted at edge N into an empty pipeline drives mem_we=1 after edge N+1. Total buffering is DEPTH+1 pixels.
- FSM states: RUN, CLEAR_WAIT, CLEAR_FILL.
  - RUN → CLEAR_WAIT on clear_req=1. clear_colour is latched at that edge, and in_ready drops after the same edge.
  - CLEAR_WAIT → CLEAR_FILL when the FIFO is empty and (mem_we=0 or the final write is accepted this cycle). Pixels accepted before the clear are always written first.
  - CLEAR_FILL: mem_we=1, mem_data=latched colour, mem_addr=counter. The counter starts at 0 and increments on each mem_ready.
  - After the write at address H_RES*V_RES-1 (19199) is accepted: clear_done=1 for one cycle, counter reset to 0, return to RUN.
  - clear_req while in CLEAR_WAIT or CLEAR_FILL is ignored.
- busy = (state!=RUN) | (fifo_count!=0) | mem_we.

Decomposition:
- Package plot_pkg holds:
  - H_RES, V_RES, PIX_COUNT (H_RES*V_RES);
  - state encodings for RUN, CLEAR_WAIT, CLEAR_FILL;
  - the address function.
- Sub-module pixel_fifo: synchronous FIFO with DEPTH entries and width ADDR_W+COLOUR_W, providing push, pop, full, empty and count.
  - Simultaneous push and pop when non-empty keeps the count unchanged.

Test Plan:
1. Reset held 2 cycles → mem_we=0, busy=0, fifo_count=0, in_ready=1, drop=0.
2. mem_ready=1; one request x=79, y=63, colour=3'b010 → one edge later mem_we=1 with mem_addr=10159, mem_data=3'b010, for exactly one cycle; busy returns to 0.
3. mem_ready=0; 10 consecutive requests → first 9 accepted (fifo_count=8), in_ready=0 and drop pulses on the 10th.
   - Then mem_ready=1 → 9 writes in request order on consecutive cycles.
4. Request x=160, y=5 → drop pulse, no mem_we. Request x=159, y=119 → write at mem_addr=19199.
5. Three pixels queued with mem_ready=0, then clear_req with clear_colour=3'b000 and mem_ready=1:
   - the three pixels are written first;
   - then 19200 writes at addresses 0..19199 with data 0;
   - clear_done pulses once; in_ready=0 throughout the clear.
6. Reset asserted while CLEAR_FILL is at address 500 → after that edge mem_we=0, state RUN, in_ready=1, fifo_count=0, and no clear_done pulse.
